// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath blocks.
package rsa_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int RSA_BITS = 65;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mod_div_step.sv
// One combinational restoring-division iteration: shift in a dividend bit,
// subtract the divisor when it fits and report the resulting quotient bit.
module mod_div_step #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH:0]   r,
  input  logic             d_bit,
  input  logic [WIDTH-1:0] x,
  output logic [WIDTH:0]   r_next,
  output logic             qbit
);

  logic [WIDTH:0] t;
  logic [WIDTH:0] diff;
  // The remainder is always below x, so its top bit is known zero here.
  logic           unused_r_msb;

  assign unused_r_msb = r[WIDTH];

  // Trial subtraction and restore.
  always_comb begin
    t    = {r[WIDTH-1:0], d_bit};
    diff = t - {1'b0, x};
    if (t >= {1'b0, x}) begin
      r_next = diff;
      qbit   = 1'b1;
    end else begin
      r_next = t;
      qbit   = 1'b0;
    end
  end

endmodule

// File: rtl/mod_seq_div.sv
// Sequential restoring divider: M = Y mod X and Q = Y div X, one quotient bit
// per cycle, with divide-by-zero flag and a level-held go/done handshake.
module mod_seq_div
  import rsa_pkg::*;
#(
  parameter int WIDTH = RSA_BITS,
  parameter int CNT_W = cnt_width(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             go,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic [WIDTH-1:0] M,
  output logic [WIDTH-1:0] Q,
  output logic             done,
  output logic             busy,
  output logic             div_zero
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] xreg, xreg_nxt;
  logic [WIDTH:0]   r, r_nxt;
  logic [WIDTH-1:0] d, d_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] m_nxt, q_nxt;
  logic             done_nxt, busy_nxt, dz_nxt;
  logic [WIDTH:0]   step_r;
  logic             step_q;

  mod_div_step #(.WIDTH(WIDTH)) u_step (
    .r      (r),
    .d_bit  (d[WIDTH-1]),
    .x      (xreg),
    .r_next (step_r),
    .qbit   (step_q)
  );

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      xreg     <= {WIDTH{1'b0}};
      r        <= {(WIDTH+1){1'b0}};
      d        <= {WIDTH{1'b0}};
      cnt      <= {CNT_W{1'b0}};
      M        <= {WIDTH{1'b0}};
      Q        <= {WIDTH{1'b0}};
      done     <= 1'b0;
      busy     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_nxt;
      xreg     <= xreg_nxt;
      r        <= r_nxt;
      d        <= d_nxt;
      cnt      <= cnt_nxt;
      M        <= m_nxt;
      Q        <= q_nxt;
      done     <= done_nxt;
      busy     <= busy_nxt;
      div_zero <= dz_nxt;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_nxt = state;
    xreg_nxt  = xreg;
    r_nxt     = r;
    d_nxt     = d;
    cnt_nxt   = cnt;
    m_nxt     = M;
    q_nxt     = Q;
    done_nxt  = 1'b0;
    busy_nxt  = 1'b0;
    dz_nxt    = div_zero;
    case (state)
      IDLE: begin
        if (go) begin
          if (X == {WIDTH{1'b0}}) begin
            // Zero divisor: report Y as remainder and an all-ones quotient.
            dz_nxt    = 1'b1;
            r_nxt     = {1'b0, Y};
            d_nxt     = {WIDTH{1'b1}};
            state_nxt = DONE;
          end else begin
            dz_nxt    = 1'b0;
            xreg_nxt  = X;
            r_nxt     = {(WIDTH+1){1'b0}};
            d_nxt     = Y;
            cnt_nxt   = CNT_W'(WIDTH);
            busy_nxt  = 1'b1;
            state_nxt = CALC;
          end
        end else begin
          state_nxt = IDLE;
        end
      end
      CALC: begin
        r_nxt   = step_r;
        d_nxt   = {d[WIDTH-2:0], step_q};
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt = DONE;
        end else begin
          busy_nxt  = 1'b1;
        end
      end
      DONE: begin
        m_nxt = r[WIDTH-1:0];
        q_nxt = d;
        // A requester that already dropped go still sees a one-cycle done.
        done_nxt = go || !done;
        if (!go) begin
          state_nxt = IDLE;
        end else begin
          state_nxt = DONE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mod_seq_div.sv
// Directed and random checks of mod_seq_div at WIDTH=65 and WIDTH=8.
module tb_mod_seq_div;

  logic        clk = 1'b0;
  logic        reset, go, go8;
  logic [64:0] X, Y, M, Q;
  logic        done, busy, div_zero;
  logic [7:0]  X8, Y8, M8, Q8;
  logic        done8, busy8, dz8;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  mod_seq_div #(.WIDTH(65)) dut (
    .clk(clk), .reset(reset), .go(go), .X(X), .Y(Y),
    .M(M), .Q(Q), .done(done), .busy(busy), .div_zero(div_zero)
  );

  mod_seq_div #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .go(go8), .X(X8), .Y(Y8),
    .M(M8), .Q(Q8), .done(done8), .busy(busy8), .div_zero(dz8)
  );

  task automatic run65(input logic [64:0] x, input logic [64:0] y,
                       output int lat, output int bcnt);
    @(negedge clk);
    X = x; Y = y; go = 1'b1;
    lat = 0; bcnt = 0;
    @(posedge clk); #1;
    if (busy) bcnt++;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
      if (busy) bcnt++;
    end
  endtask

  task automatic release65();
    @(negedge clk);
    go = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; go = 1'b0; go8 = 1'b0;
    X = '0; Y = '0; X8 = '0; Y8 = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({M, Q, done, busy, div_zero} !== {133{1'b0}}) begin
      errors++;
      $display("FAIL reset_outputs: M=%0h Q=%0h done=%b busy=%b dz=%b, required all 0",
               M, Q, done, busy, div_zero);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_basic();
    int lat, bcnt;
    run65(65'd4, 65'd21, lat, bcnt);
    checks++; if (lat !== 66) begin errors++; $display("FAIL basic_latency: got %0d required 66", lat); end
    checks++; if (bcnt !== 65) begin errors++; $display("FAIL basic_busy_cycles: got %0d required 65", bcnt); end
    checks++; if (M !== 65'd1) begin errors++; $display("FAIL basic_M: got %0d required 1", M); end
    checks++; if (Q !== 65'd5) begin errors++; $display("FAIL basic_Q: got %0d required 5", Q); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL basic_dz: got %b required 0", div_zero); end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (done !== 1'b1 || M !== 65'd1 || Q !== 65'd5) begin
        errors++;
        $display("FAIL basic_hold: done=%b M=%0d Q=%0d required 1/1/5", done, M, Q);
      end
    end
    release65();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_fall: got %b required 0", done); end
    checks++; if (M !== 65'd1) begin errors++; $display("FAIL basic_M_kept: got %0d required 1", M); end
  endtask

  task automatic test_large();
    int lat, bcnt;
    logic [64:0]  y;
    logic [64:0]  x;
    logic [129:0] recon;
    x = 65'd1073602561;
    y = 65'h1_0000_0000_0000_0000;
    run65(x, y, lat, bcnt);
    recon = Q * x;
    recon = recon + M;
    checks++; if (M !== 65'd35790575) begin errors++; $display("FAIL large_M: got %0d required 35790575", M); end
    checks++; if (Q !== y / x) begin errors++; $display("FAIL large_Q: got %0d required %0d", Q, y / x); end
    checks++; if (recon !== {65'd0, y}) begin errors++; $display("FAIL large_recon: got %0h required %0h", recon, y); end
    checks++; if (bcnt !== 65) begin errors++; $display("FAIL large_busy_cycles: got %0d required 65", bcnt); end
    release65();
  endtask

  task automatic test_div_zero();
    int lat, bcnt;
    run65(65'd0, 65'd123, lat, bcnt);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_latency: got %0d required 1", lat); end
    checks++; if (bcnt !== 0) begin errors++; $display("FAIL dz_busy: got %0d required 0", bcnt); end
    checks++; if (M !== 65'd123) begin errors++; $display("FAIL dz_M: got %0d required 123", M); end
    checks++; if (Q !== {65{1'b1}}) begin errors++; $display("FAIL dz_Q: got %0h required all ones", Q); end
    checks++; if (div_zero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b required 1", div_zero); end
    release65();
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL dz_done_fall: got %b required 0", done); end
  endtask

  task automatic test_corners();
    logic [64:0] xs[3] = '{65'd1, 65'd21, 65'd9};
    logic [64:0] ys[3] = '{{65{1'b1}}, 65'd4, 65'd0};
    logic [64:0] ms[3] = '{65'd0, 65'd4, 65'd0};
    logic [64:0] qs[3] = '{{65{1'b1}}, 65'd0, 65'd0};
    int lat, bcnt;
    for (int i = 0; i < 3; i++) begin
      run65(xs[i], ys[i], lat, bcnt);
      checks++;
      if (M !== ms[i] || Q !== qs[i] || div_zero !== 1'b0) begin
        errors++;
        $display("FAIL corner_%0d: M=%0h Q=%0h dz=%b required M=%0h Q=%0h dz=0",
                 i, M, Q, div_zero, ms[i], qs[i]);
      end
      release65();
    end
  endtask

  task automatic test_random65();
    int lat, bcnt;
    logic [64:0] x, y;
    for (int i = 0; i < 12; i++) begin
      x = {$urandom, $urandom, $urandom};
      x = x >> $urandom_range(0, 60);
      if (x == 65'd0) x = 65'd1;
      y = {$urandom, $urandom, $urandom};
      run65(x, y, lat, bcnt);
      checks++;
      if (M !== y % x || Q !== y / x) begin
        errors++;
        $display("FAIL rand65_%0d: M=%0h Q=%0h required M=%0h Q=%0h", i, M, Q, y % x, y / x);
      end
      release65();
    end
  endtask

  task automatic test_random8();
    int lat;
    logic [7:0] x, y;
    for (int i = 0; i < 30; i++) begin
      x = 8'($urandom_range(1, 255));
      y = 8'($urandom_range(0, 255));
      @(negedge clk);
      X8 = x; Y8 = y; go8 = 1'b1;
      lat = 0;
      @(posedge clk); #1;
      while (!done8 && lat < 50) begin
        @(posedge clk); #1;
        lat++;
      end
      checks++;
      if (lat !== 9 || M8 !== y % x || Q8 !== y / x) begin
        errors++;
        $display("FAIL rand8_%0d: lat=%0d M=%0d Q=%0d required lat=9 M=%0d Q=%0d",
                 i, lat, M8, Q8, y % x, y / x);
      end
      @(negedge clk);
      go8 = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_op();
    int lat, bcnt;
    @(negedge clk);
    X = 65'd12345; Y = 65'h1_2345_6789_ABCD_EF01; go = 1'b1;
    repeat (31) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b required 1", busy); end
    reset = 1'b1;
    #1;
    checks++;
    if ({M, Q, done, busy, div_zero} !== {133{1'b0}}) begin
      errors++;
      $display("FAIL rst_async: M=%0h Q=%0h done=%b busy=%b dz=%b required all 0",
               M, Q, done, busy, div_zero);
    end
    go = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    run65(65'd7, 65'd50, lat, bcnt);
    checks++; if (M !== 65'd1 || Q !== 65'd7) begin errors++; $display("FAIL rst_after: M=%0d Q=%0d required 1/7", M, Q); end
    checks++; if (lat !== 66) begin errors++; $display("FAIL rst_after_latency: got %0d required 66", lat); end
    release65();
  endtask

  task automatic test_go_drop();
    int lat;
    @(negedge clk);
    X = 65'd100; Y = 65'd12345; go = 1'b1;
    repeat (6) @(posedge clk);
    @(negedge clk);
    go = 1'b0; X = 65'd3; Y = 65'd7;
    lat = 0;
    @(posedge clk); #1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL drop_done: got %b required 1", done); end
    checks++; if (M !== 65'd45 || Q !== 65'd123) begin errors++; $display("FAIL drop_result: M=%0d Q=%0d required 45/123", M, Q); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL drop_done_fall: got %b required 0", done); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_large();
    test_div_zero();
    test_corners();
    test_random65();
    test_random8();
    test_reset_mid_op();
    test_go_drop();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
